// File: rtl/pkt_gen_pkg.sv
// Shared definitions for the packet traffic generator:
//   chan_state_e  - per-channel FSM states
//   DEST_*        - cfg_dest_mode encodings
//   LFSR_TAPS     - Galois mask for x^64+x^63+x^61+x^60+1
//   port_w/hdr_*  - header field widths and offsets
//   lfsr_step     - one Galois LFSR shift
package pkt_gen_pkg;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_SOP,
    CH_HDR,
    CH_PAY,
    CH_EOP,
    CH_GAP,
    CH_DONE
  } chan_state_e;

  localparam logic [1:0] DEST_OWN   = 2'd0;
  localparam logic [1:0] DEST_FIXED = 2'd1;
  localparam logic [1:0] DEST_LFSR  = 2'd2;
  localparam logic [1:0] DEST_RSVD  = 2'd3;

  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  function automatic int unsigned port_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned hdr_pri_lo(input int unsigned pw);
    return pw;
  endfunction

  function automatic int unsigned hdr_len_lo(input int unsigned pw, input int unsigned prw);
    return pw + prw;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/pkt_gen_chan.sv
// One write channel of the packet traffic generator.
//   clk, rst_n     - clock, async active-low reset
//   load           - accepted start: loads pkt_cnt into the packet counter
//   beat_en        - beat strobe; all state/output changes happen on it
//   clr            - run-complete pulse; returns DONE to IDLE
//   pkt_cnt        - packets to send (raw, sampled on load)
//   len..gap       - latched run configuration
//   rdy            - downstream ready, checked only when leaving IDLE
//   sop/vld/eop/data - registered write interface
//   fin            - channel has nothing left to send in this run
module pkt_gen_chan
  import pkt_gen_pkg::*;
#(
  parameter int unsigned CHAN           = 0,
  parameter int unsigned NUM_PORTS      = 16,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned PRIORITY_WIDTH = 3,
  parameter int unsigned LEN_WIDTH      = 7,
  parameter logic [63:0] SEED           = 64'h1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          beat_en,
  input  logic                          clr,
  input  logic [15:0]                   pkt_cnt,
  input  logic [LEN_WIDTH-1:0]          len,
  input  logic [1:0]                    dest_mode,
  input  logic [port_w(NUM_PORTS)-1:0]  dest,
  input  logic [PRIORITY_WIDTH-1:0]     pri,
  input  logic                          pri_rand,
  input  logic [7:0]                    gap,
  input  logic                          rdy,
  output logic                          sop,
  output logic                          vld,
  output logic                          eop,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          fin
);

  localparam int unsigned PW     = port_w(NUM_PORTS);
  localparam int unsigned PRI_LO = hdr_pri_lo(PW);
  localparam int unsigned LEN_LO = hdr_len_lo(PW, PRIORITY_WIDTH);
  localparam int unsigned CW     = (LEN_WIDTH > 8) ? LEN_WIDTH : 8;
  localparam logic [63:0] RAW_SEED = SEED ^ 64'(CHAN + 1);
  // SEED ^ (CHAN+1) is zero only when SEED == CHAN+1; SEED itself is then nonzero.
  localparam logic [63:0] LFSR_INIT = (RAW_SEED != 64'h0) ? RAW_SEED : SEED;

  chan_state_e           state;
  logic [15:0]           pkts_left;
  logic [CW-1:0]         cnt;
  logic [63:0]           lfsr;
  logic [PW-1:0]         hdr_dest;
  logic [PRIORITY_WIDTH-1:0] hdr_pri;
  logic [DATA_WIDTH-1:0] header;

  always_comb begin
    hdr_dest = PW'(CHAN);
    case (dest_mode)
      DEST_FIXED: hdr_dest = dest;
      DEST_LFSR:  hdr_dest = lfsr[PW-1:0];
      DEST_OWN, DEST_RSVD: hdr_dest = PW'(CHAN);
      default:    hdr_dest = PW'(CHAN);
    endcase
    hdr_pri = pri_rand ? lfsr[PW +: PRIORITY_WIDTH] : pri;
    header = '0;
    header[PW-1:0] = hdr_dest;
    header[PRI_LO +: PRIORITY_WIDTH] = hdr_pri;
    header[LEN_LO +: LEN_WIDTH] = len;
  end

  assign fin = (state == CH_DONE) || ((state == CH_IDLE) && (pkts_left == '0));

  // Outputs describe the state being entered, so they are written alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CH_IDLE;
      pkts_left <= '0;
      cnt       <= '0;
      lfsr      <= LFSR_INIT;
      sop       <= 1'b0;
      vld       <= 1'b0;
      eop       <= 1'b0;
      data      <= '0;
    end else begin
      if (load) pkts_left <= pkt_cnt;
      if (clr && (state == CH_DONE)) begin
        state <= CH_IDLE;
      end else if (beat_en) begin
        sop  <= 1'b0;
        vld  <= 1'b0;
        eop  <= 1'b0;
        data <= '0;
        case (state)
          CH_IDLE: begin
            if (pkts_left == '0) begin
              state <= CH_DONE;
            end else if (rdy) begin
              state <= CH_SOP;
              sop   <= 1'b1;
            end
          end
          CH_SOP: begin
            state <= CH_HDR;
            vld   <= 1'b1;
            data  <= header;
          end
          CH_HDR: begin
            vld <= 1'b1;
            if (len != '0) begin
              state <= CH_PAY;
              data  <= DATA_WIDTH'(lfsr);
              lfsr  <= lfsr_step(lfsr);
              cnt   <= CW'(1);
            end else begin
              state <= CH_EOP;
              eop   <= 1'b1;
            end
          end
          CH_PAY: begin
            vld <= 1'b1;
            if (cnt == CW'(len)) begin
              state <= CH_EOP;
              eop   <= 1'b1;
            end else begin
              data <= DATA_WIDTH'(lfsr);
              lfsr <= lfsr_step(lfsr);
              cnt  <= cnt + CW'(1);
            end
          end
          CH_EOP: begin
            pkts_left <= pkts_left - 16'd1;
            if (gap != 8'd0) begin
              state <= CH_GAP;
              cnt   <= CW'(1);
            end else begin
              state <= CH_IDLE;
            end
          end
          CH_GAP: begin
            if (cnt == CW'(gap)) state <= CH_IDLE;
            else                 cnt   <= cnt + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/pkt_traffic_gen.sv
// Multi-port packet traffic generator driving SRAM-controller write ports.
//   clk, rst_n          - clock, async active-low reset
//   start               - one-cycle pulse; latches cfg_* and starts a run when idle
//   cfg_len/pkt_cnt/dest_mode/dest/pri/pri_rand/gap - run configuration
//   port_rdy            - per-port ready, checked before each packet
//   wr_sop/vld/eop/data - per-port write interface (data packed, port i at i*DATA_WIDTH)
//   busy                - run in progress
//   done                - one-cycle pulse when every channel has finished
module pkt_traffic_gen
  import pkt_gen_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 16,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned PRIORITY_WIDTH = 3,
  parameter int unsigned LEN_WIDTH      = 7,
  parameter int unsigned RATE_DIV       = 16,
  parameter logic [63:0] SEED           = 64'h1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            cfg_len,
  input  logic [15:0]                     cfg_pkt_cnt,
  input  logic [1:0]                      cfg_dest_mode,
  input  logic [port_w(NUM_PORTS)-1:0]    cfg_dest,
  input  logic [PRIORITY_WIDTH-1:0]       cfg_pri,
  input  logic                            cfg_pri_rand,
  input  logic [7:0]                      cfg_gap,
  input  logic [NUM_PORTS-1:0]            port_rdy,
  output logic [NUM_PORTS-1:0]            wr_sop,
  output logic [NUM_PORTS-1:0]            wr_vld,
  output logic [NUM_PORTS-1:0]            wr_eop,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned PW    = port_w(NUM_PORTS);
  localparam int unsigned CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RATE_DIV - 1);

  logic [CNT_W-1:0]          div_cnt;
  logic                      beat_en;
  logic                      accept;
  logic [NUM_PORTS-1:0]      fin;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [1:0]                dest_mode_q;
  logic [PW-1:0]             dest_q;
  logic [PRIORITY_WIDTH-1:0] pri_q;
  logic                      pri_rand_q;
  logic [7:0]                gap_q;

  assign accept  = start && !busy;
  assign beat_en = busy && (div_cnt == DIV_LAST);

  // Completion is seen on the beat where the last channel moves into DONE,
  // so done/busy change on that same edge rather than a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_cnt     <= '0;
      len_q       <= '0;
      dest_mode_q <= '0;
      dest_q      <= '0;
      pri_q       <= '0;
      pri_rand_q  <= 1'b0;
      gap_q       <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy        <= 1'b1;
        div_cnt     <= '0;
        len_q       <= cfg_len;
        dest_mode_q <= cfg_dest_mode;
        dest_q      <= cfg_dest;
        pri_q       <= cfg_pri;
        pri_rand_q  <= cfg_pri_rand;
        gap_q       <= cfg_gap;
      end else if (busy) begin
        div_cnt <= beat_en ? '0 : div_cnt + 1'b1;
        if (beat_en && (&fin)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_chan
    pkt_gen_chan #(
      .CHAN           (g),
      .NUM_PORTS      (NUM_PORTS),
      .DATA_WIDTH     (DATA_WIDTH),
      .PRIORITY_WIDTH (PRIORITY_WIDTH),
      .LEN_WIDTH      (LEN_WIDTH),
      .SEED           (SEED)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .beat_en   (beat_en),
      .clr       (done),
      .pkt_cnt   (cfg_pkt_cnt),
      .len       (len_q),
      .dest_mode (dest_mode_q),
      .dest      (dest_q),
      .pri       (pri_q),
      .pri_rand  (pri_rand_q),
      .gap       (gap_q),
      .rdy       (port_rdy[g]),
      .sop       (wr_sop[g]),
      .vld       (wr_vld[g]),
      .eop       (wr_eop[g]),
      .data      (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .fin       (fin[g])
    );
  end

endmodule

// File: tb/tb_pkt_traffic_gen.sv
// Directed bench for pkt_traffic_gen: a default 16-port instance (RATE_DIV=16)
// and a 2-port instance with RATE_DIV=1.
module tb_pkt_traffic_gen;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [6:0]    cfg_len;
  logic [15:0]   cfg_pkt_cnt;
  logic [1:0]    cfg_dest_mode;
  logic [3:0]    cfg_dest;
  logic [2:0]    cfg_pri;
  logic          cfg_pri_rand;
  logic [7:0]    cfg_gap;
  logic [15:0]   port_rdy;
  logic [15:0]   wr_sop, wr_vld, wr_eop;
  logic [1023:0] wr_data;
  logic          busy, done;

  logic          start_b;
  logic [6:0]    cfg_len_b;
  logic [15:0]   cfg_pkt_cnt_b;
  logic [0:0]    cfg_dest_b;
  logic [1:0]    port_rdy_b;
  logic [1:0]    wr_sop_b, wr_vld_b, wr_eop_b;
  logic [127:0]  wr_data_b;
  logic          busy_b, done_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  pkt_traffic_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_pkt_cnt(cfg_pkt_cnt),
    .cfg_dest_mode(cfg_dest_mode), .cfg_dest(cfg_dest), .cfg_pri(cfg_pri),
    .cfg_pri_rand(cfg_pri_rand), .cfg_gap(cfg_gap), .port_rdy(port_rdy),
    .wr_sop(wr_sop), .wr_vld(wr_vld), .wr_eop(wr_eop), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  pkt_traffic_gen #(.NUM_PORTS(2), .RATE_DIV(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_len(cfg_len_b), .cfg_pkt_cnt(cfg_pkt_cnt_b),
    .cfg_dest_mode(2'd0), .cfg_dest(cfg_dest_b), .cfg_pri(3'd0),
    .cfg_pri_rand(1'b0), .cfg_gap(8'd0), .port_rdy(port_rdy_b),
    .wr_sop(wr_sop_b), .wr_vld(wr_vld_b), .wr_eop(wr_eop_b), .wr_data(wr_data_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] pdata(input int p);
    return wr_data[p*64 +: 64];
  endfunction

  task automatic beat();
    repeat (16) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    cfg_len = '0; cfg_pkt_cnt = '0; cfg_dest_mode = '0; cfg_dest = '0;
    cfg_pri = '0; cfg_pri_rand = 1'b0; cfg_gap = '0; port_rdy = '1;
    start_b = 1'b0; cfg_len_b = '0; cfg_pkt_cnt_b = '0; cfg_dest_b = '0; port_rdy_b = '1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sop",  64'(wr_sop), 64'h0);
    check("rst_vld",  64'(wr_vld), 64'h0);
    check("rst_busy", 64'(busy),   64'h0);
    check("rst_done", 64'(done),   64'h0);

    // Basic packet: len 4, one packet, own-index dest
    cfg_len = 7'd4; cfg_pkt_cnt = 16'd1; cfg_dest_mode = 2'd0; cfg_gap = 8'd0;
    pulse_start();
    check("t1_busy", 64'(busy), 64'h1);
    beat();
    check("t1_sop", 64'(wr_sop), 64'hFFFF);
    check("t1_sop_vld", 64'(wr_vld), 64'h0);
    beat();
    check("t1_hdr_vld", 64'(wr_vld), 64'hFFFF);
    for (int p = 0; p < 16; p++) check($sformatf("t1_hdr_p%0d", p), pdata(p), 64'(p) | 64'h200);
    beat();
    check("t1_pay0_p0", pdata(0), 64'h1);
    check("t1_pay0_p1", pdata(1), 64'h3);
    beat();
    check("t1_pay1_p1", pdata(1), 64'hD800_0000_0000_0001);
    beat();
    check("t1_pay2_p1", pdata(1), 64'hB400_0000_0000_0000);
    beat();
    check("t1_pay3_p1", pdata(1), 64'h5A00_0000_0000_0000);
    check("t1_pay3_p0", pdata(0), 64'h3600_0000_0000_0000);
    beat();
    check("t1_eop", 64'(wr_eop), 64'hFFFF);
    check("t1_eop_vld", 64'(wr_vld), 64'hFFFF);
    check("t1_eop_data", pdata(1), 64'h0);
    beat();
    check("t1_idle_vld", 64'(wr_vld), 64'h0);
    check("t1_idle_eop", 64'(wr_eop), 64'h0);
    repeat (15) @(negedge clk);
    check("t1_done_early", 64'(done), 64'h0);
    @(negedge clk);
    check("t1_done", 64'(done), 64'h1);
    check("t1_busy_end", 64'(busy), 64'h0);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'h0);

    // RATE_DIV=1, zero-length packets
    cfg_len_b = 7'd0; cfg_pkt_cnt_b = 16'd1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    check("t2_sop", 64'(wr_sop_b), 64'h3);
    @(negedge clk);
    check("t2_hdr_vld", 64'(wr_vld_b), 64'h3);
    check("t2_hdr_sop", 64'(wr_sop_b), 64'h0);
    check("t2_hdr_p0", wr_data_b[63:0], 64'h0);
    check("t2_hdr_p1", wr_data_b[127:64], 64'h1);
    @(negedge clk);
    check("t2_eop", 64'(wr_eop_b), 64'h3);
    check("t2_eop_vld", 64'(wr_vld_b), 64'h3);
    check("t2_eop_data", wr_data_b[127:64], 64'h0);
    @(negedge clk);
    check("t2_idle_vld", 64'(wr_vld_b), 64'h0);
    check("t2_idle_done", 64'(done_b), 64'h0);
    @(negedge clk);
    check("t2_done", 64'(done_b), 64'h1);
    check("t2_busy", 64'(busy_b), 64'h0);

    // Fixed dest 9, pri 5, 3 packets of len 1, gap 2; start mid-run ignored
    cfg_len = 7'd1; cfg_pkt_cnt = 16'd3; cfg_dest_mode = 2'd1; cfg_dest = 4'd9;
    cfg_pri = 3'd5; cfg_gap = 8'd2;
    pulse_start();
    for (int b = 1; b <= 21; b++) begin
      int k;
      k = (b - 1) % 7;
      if (b == 6) begin
        cfg_dest = 4'd3; cfg_pkt_cnt = 16'd1; cfg_len = 7'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
      end else begin
        beat();
      end
      check($sformatf("t3_sop_b%0d", b), 64'(wr_sop), (k == 0) ? 64'hFFFF : 64'h0);
      check($sformatf("t3_vld_b%0d", b), 64'(wr_vld), (k >= 1 && k <= 3) ? 64'hFFFF : 64'h0);
      check($sformatf("t3_eop_b%0d", b), 64'(wr_eop), (k == 3) ? 64'hFFFF : 64'h0);
      if (k == 1) begin
        check($sformatf("t3_hdr_p0_b%0d", b),  pdata(0),  64'hD9);
        check($sformatf("t3_hdr_p15_b%0d", b), pdata(15), 64'hD9);
      end
    end
    repeat (15) @(negedge clk);
    check("t3_done_early", 64'(done), 64'h0);
    @(negedge clk);
    check("t3_done", 64'(done), 64'h1);
    check("t3_busy", 64'(busy), 64'h0);

    // Backpressure on port 5 for 10 beats
    cfg_len = 7'd0; cfg_pkt_cnt = 16'd1; cfg_dest_mode = 2'd0; cfg_pri = 3'd0; cfg_gap = 8'd0;
    port_rdy = 16'hFFDF;
    @(negedge clk);
    pulse_start();
    for (int b = 1; b <= 14; b++) begin
      if (b == 11) port_rdy = '1;
      beat();
      if (b == 1)  check("t4_sop_b1", 64'(wr_sop), 64'hFFDF);
      if (b == 3)  check("t4_eop_b3", 64'(wr_eop), 64'hFFDF);
      if (b == 10) check("t4_sop_b10", 64'(wr_sop), 64'h0);
      if (b == 11) check("t4_sop_b11", 64'(wr_sop), 64'h0020);
      if (b == 12) begin
        check("t4_vld_b12", 64'(wr_vld), 64'h0020);
        check("t4_hdr_p5", pdata(5), 64'h5);
      end
      if (b == 13) check("t4_eop_b13", 64'(wr_eop), 64'h0020);
      if (b == 14) begin
        check("t4_done_b14", 64'(done), 64'h0);
        check("t4_busy_b14", 64'(busy), 64'h1);
      end
    end
    beat();
    check("t4_done", 64'(done), 64'h1);
    check("t4_busy", 64'(busy), 64'h0);

    // Zero packet count
    cfg_pkt_cnt = 16'd0;
    @(negedge clk);
    pulse_start();
    repeat (15) @(negedge clk);
    check("t5_done_early", 64'(done), 64'h0);
    check("t5_busy_early", 64'(busy), 64'h1);
    @(negedge clk);
    check("t5_done", 64'(done), 64'h1);
    check("t5_busy", 64'(busy), 64'h0);
    check("t5_sop", 64'(wr_sop), 64'h0);
    @(negedge clk);
    check("t5_done_pulse", 64'(done), 64'h0);

    // Reset in the middle of the payload
    cfg_len = 7'd4; cfg_pkt_cnt = 16'd1;
    pulse_start();
    repeat (3) beat();
    check("t6_pay_vld", 64'(wr_vld), 64'hFFFF);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld",  64'(wr_vld), 64'h0);
    check("t6_rst_eop",  64'(wr_eop), 64'h0);
    check("t6_rst_data", pdata(3), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    beat();
    check("t6_post_vld", 64'(wr_vld), 64'h0);
    check("t6_post_busy", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
